// File: rtl/mult_dot_product_ctrl_pkg.sv
// Shared definitions for the dot-product sequencer.
//  - state_t : sequencer FSM states
//  - DEF_*   : default operand/product widths and vector length
//  - cnt_w() : width needed to hold a pair count of 0..vec_len
package mult_dot_product_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_WAIT  = 3'd2,
        S_ACC   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int DEF_OP_W    = 16;
    localparam int DEF_PROD_W  = 32;
    localparam int DEF_VEC_LEN = 8;

    function automatic int cnt_w(input int vec_len);
        return $clog2(vec_len + 1);
    endfunction

endpackage

// File: rtl/mult_dot_product_ctrl_dp_accumulator.sv
// Dot-product accumulator: unsigned running sum, sticky carry-out flag and
// pair counter.
//  clk, reset : clock / synchronous active-high reset
//  clr        : clear sum, flag and count (end of vector handed off)
//  en         : add din to the sum and bump the count
//  din        : unsigned product, zero-extended into the sum
//  acc        : running sum, wraps modulo 2^ACC_W
//  count      : number of products added since the last clear
//  ovf        : set once the sum has carried out of ACC_W bits
module dp_accumulator #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [PROD_W-1:0] din,
    output logic [ACC_W-1:0]  acc,
    output logic [CNT_W-1:0]  count,
    output logic              ovf
);

    // One extra bit on top of the sum exposes the carry-out.
    logic [ACC_W:0] sum_ext;

    always_comb begin
        sum_ext = {1'b0, acc} + {{(ACC_W - PROD_W + 1){1'b0}}, din};
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (en) begin
            acc   <= sum_ext[ACC_W-1:0];
            count <= count + 1'b1;
            ovf   <= ovf | sum_ext[ACC_W];
        end
    end

endmodule

// File: rtl/mult_dot_product_ctrl.sv
// Sequencer around an external fixed-latency multiplier.
// Accepts operand pairs, presents them to the multiplier (held for the whole
// operation), releases the multiplier reset for MULT_LAT cycles, then adds
// the product into a dot-product sum handed downstream on a valid/ready port.
//  clk, reset           : clock / synchronous active-high reset
//  in_valid/in_ready    : operand pair handshake (ready only in IDLE)
//  in_a, in_b, in_last  : operands and end-of-vector marker
//  mul_reset/mul_x/mul_y: drive the multiplier
//  mul_out              : multiplier product
//  sum_valid/sum_ready  : result handshake
//  sum_data/count/ovf   : accumulated sum, pair count, carry-out flag
module mult_dot_product_ctrl
    import mult_dot_product_ctrl_pkg::*;
#(
    parameter  int OP_W     = DEF_OP_W,
    parameter  int PROD_W   = DEF_PROD_W,
    parameter  int ACC_W    = 40,
    parameter  int VEC_LEN  = DEF_VEC_LEN,
    parameter  int MULT_LAT = 10,
    localparam int CNT_W    = cnt_w(VEC_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic              in_last,
    output logic              mul_reset,
    output logic [OP_W-1:0]   mul_x,
    output logic [OP_W-1:0]   mul_y,
    input  logic [PROD_W-1:0] mul_out,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic [ACC_W-1:0]  sum_data,
    output logic [CNT_W-1:0]  sum_count,
    output logic              sum_ovf
);

    localparam int WAIT_W = $clog2(MULT_LAT + 1);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              last_q;
    logic              accept;
    logic              handoff;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  acc_count;
    logic              acc_ovf;

    assign in_ready = (state == S_IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    // Result leaves only once it has actually been presented.
    assign handoff  = (state == S_DONE) && sum_valid && sum_ready;

    dp_accumulator #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) u_acc (
        .clk    (clk),
        .reset  (reset),
        .clr    (handoff),
        .en     (state == S_ACC),
        .din    (mul_out),
        .acc    (acc),
        .count  (acc_count),
        .ovf    (acc_ovf)
    );

    always_comb begin
        state_nxt = state;
        mul_reset = 1'b1;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_WAIT;
            S_WAIT: begin
                mul_reset = 1'b0;
                if (wait_cnt == '0) state_nxt = S_ACC;
            end
            S_ACC: begin
                // acc_count is still the pre-increment value here.
                if (last_q || acc_count == CNT_W'(VEC_LEN - 1)) state_nxt = S_DONE;
                else                                            state_nxt = S_IDLE;
            end
            S_DONE:  if (handoff) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            mul_x     <= '0;
            mul_y     <= '0;
            last_q    <= 1'b0;
            sum_valid <= 1'b0;
            sum_data  <= '0;
            sum_count <= '0;
            sum_ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mul_x  <= in_a;
                mul_y  <= in_b;
                last_q <= in_last;
            end
            // WAIT spans MULT_LAT cycles: load N-1, leave when it reads 0.
            if (state == S_CLEAR)
                wait_cnt <= WAIT_W'(MULT_LAT - 1);
            else if (state == S_WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - 1'b1;
            // Snapshot the result on the first DONE cycle so it stays frozen
            // while the consumer stalls.
            if (state == S_DONE) begin
                if (!sum_valid) begin
                    sum_valid <= 1'b1;
                    sum_data  <= acc;
                    sum_count <= acc_count;
                    sum_ovf   <= acc_ovf;
                end else if (sum_ready) begin
                    sum_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_dot_product_ctrl.sv
module tb_mult_dot_product_ctrl;
    localparam int L = 10;

    typedef struct {
        logic [39:0] d;
        logic [3:0]  c;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sel = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, sum_ready = 1'b0;
    logic [15:0] in_a = '0, in_b = '0;

    // DUT0: ACC_W=40, DUT1: ACC_W=33
    logic        in_ready0, mul_reset0, sum_valid0, sum_ovf0;
    logic [15:0] mul_x0, mul_y0;
    logic [31:0] mul_out0;
    logic [39:0] sum_data0;
    logic [3:0]  sum_count0;
    logic        in_ready1, mul_reset1, sum_valid1, sum_ovf1;
    logic [15:0] mul_x1, mul_y1;
    logic [31:0] mul_out1;
    logic [32:0] sum_data1;
    logic [3:0]  sum_count1;

    logic        in_ready_o, mul_reset_o, sum_valid_o, sum_ovf_o;
    logic [15:0] mul_x_o;
    logic [39:0] sum_data_o;
    logic [3:0]  sum_count_o;

    int   total = 0, bad = 0, cyc = 0, acc_cyc = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    mult_dot_product_ctrl #(.ACC_W(40), .MULT_LAT(L)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid & ~sel), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_reset(mul_reset0),
        .mul_x(mul_x0), .mul_y(mul_y0), .mul_out(mul_out0), .sum_valid(sum_valid0),
        .sum_ready(sum_ready & ~sel), .sum_data(sum_data0), .sum_count(sum_count0),
        .sum_ovf(sum_ovf0));

    mult_dot_product_ctrl #(.ACC_W(33), .MULT_LAT(L)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid & sel), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_reset(mul_reset1),
        .mul_x(mul_x1), .mul_y(mul_y1), .mul_out(mul_out1), .sum_valid(sum_valid1),
        .sum_ready(sum_ready & sel), .sum_data(sum_data1), .sum_count(sum_count1),
        .sum_ovf(sum_ovf1));

    // Multiplier model: product valid L cycles after reset deasserts,
    // recognisable garbage before that.
    int mcnt0 = 0, mcnt1 = 0;
    always @(posedge clk) begin
        if (mul_reset0) mcnt0 <= 0; else if (mcnt0 < L) mcnt0 <= mcnt0 + 1;
        if (mul_reset1) mcnt1 <= 0; else if (mcnt1 < L) mcnt1 <= mcnt1 + 1;
    end
    assign mul_out0 = (mcnt0 >= L) ? 32'(mul_x0) * 32'(mul_y0) : 32'hBAD0_0BAD;
    assign mul_out1 = (mcnt1 >= L) ? 32'(mul_x1) * 32'(mul_y1) : 32'hBAD0_0BAD;

    always_comb begin
        in_ready_o  = sel ? in_ready1  : in_ready0;
        mul_reset_o = sel ? mul_reset1 : mul_reset0;
        sum_valid_o = sel ? sum_valid1 : sum_valid0;
        sum_ovf_o   = sel ? sum_ovf1   : sum_ovf0;
        mul_x_o     = sel ? mul_x1     : mul_x0;
        sum_data_o  = sel ? 40'(sum_data1) : sum_data0;
        sum_count_o = sel ? sum_count1 : sum_count0;
    end

    // Operands must not move while the multiplier is running.
    logic [15:0] px = '0, py = '0;
    logic        xy_bad = 1'b0;
    always @(negedge clk) begin
        if (!mul_reset0 && (mul_x0 !== px || mul_y0 !== py)) xy_bad <= 1'b1;
        px <= mul_x0;
        py <= mul_y0;
    end

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [39:0] d, input logic [3:0] c, input logic o);
        exp_t e;
        e.d = d; e.c = c; e.o = o;
        sbq.push_back(e);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic last, input int gap);
        int n = 0;
        repeat (gap) tick;
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        while (!in_ready_o && n < 100) begin tick; n++; end
        if (!in_ready_o) chk("in_ready_timeout", 0, 1);
        tick;
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic collect(input int hold, input bit pulses, input bit lat);
        int n = 0;
        logic [39:0] d;
        logic [3:0]  c;
        logic        o;
        exp_t        e;
        while (!sum_valid_o && n < 100) begin tick; n++; end
        if (!sum_valid_o) begin
            chk("sum_valid_timeout", 0, 1);
            return;
        end
        if (lat) chk("latency", 64'(cyc - acc_cyc), 64'(L + 3));
        d = sum_data_o; c = sum_count_o; o = sum_ovf_o;
        for (int i = 0; i < hold; i++) begin
            if (pulses) in_valid = ~in_valid;
            tick;
            chk("hold_valid", 64'(sum_valid_o), 1);
            chk("hold_data", 64'(sum_data_o), 64'(d));
            chk("hold_in_ready", 64'(in_ready_o), 0);
        end
        in_valid = 1'b0;
        sum_ready = 1'b1;
        tick;
        sum_ready = 1'b0;
        chk("post_accept_in_ready", 64'(in_ready_o), 1);
        chk("post_accept_valid", 64'(sum_valid_o), 0);
        if (sbq.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sbq.pop_front();
            chk("sum_data", 64'(d), 64'(e.d));
            chk("sum_count", 64'(c), 64'(e.c));
            chk("sum_ovf", 64'(o), 64'(e.o));
        end
    endtask

    initial begin
        // Reset values
        tick; tick;
        chk("rst_in_ready", 64'(in_ready_o), 0);
        chk("rst_mul_reset", 64'(mul_reset_o), 1);
        chk("rst_sum_valid", 64'(sum_valid_o), 0);
        reset = 1'b0;
        tick;
        chk("rst1_in_ready", 64'(in_ready_o), 1);
        chk("rst1_mul_reset", 64'(mul_reset_o), 1);
        chk("rst1_mul_x", 64'(mul_x_o), 0);
        chk("rst1_sum_data", 64'(sum_data_o), 0);
        chk("rst1_sum_count", 64'(sum_count_o), 0);
        chk("rst1_sum_ovf", 64'(sum_ovf_o), 0);
        // Stray sum_ready while idle
        sum_ready = 1'b1; tick; sum_ready = 1'b0; tick;
        chk("stray_ready_valid", 64'(sum_valid_o), 0);

        // 1: single pair with latency
        send(16'd255, 16'd255, 1'b1, 0);
        push(40'd65025, 4'd1, 1'b0);
        collect(0, 1'b0, 1'b1);

        // 2: full vector without in_last
        send(16'd128, 16'd128, 1'b0, 0);
        send(16'd128, 16'd0,   1'b0, 0);
        send(16'd128, 16'd1,   1'b0, 0);
        send(16'd25,  16'd5,   1'b0, 0);
        send(16'd64,  16'd64,  1'b0, 0);
        send(16'd36,  16'd36,  1'b0, 0);
        send(16'd11,  16'd33,  1'b0, 0);
        send(16'd80,  16'd10,  1'b0, 0);
        push(40'd23192, 4'd8, 1'b0);
        collect(0, 1'b0, 1'b1);

        // 3: consumer stall with ignored in_valid pulses
        send(16'd7, 16'd9, 1'b1, 0);
        push(40'd63, 4'd1, 1'b0);
        collect(5, 1'b1, 1'b0);

        // 4: reset during WAIT of pair 2
        send(16'd128, 16'd128, 1'b0, 0);
        send(16'd64, 16'd64, 1'b0, 0);
        repeat (4) tick;
        chk("wait_mul_reset", 64'(mul_reset_o), 0);
        reset = 1'b1;
        tick;
        chk("midrst_in_ready", 64'(in_ready_o), 0);
        chk("midrst_mul_reset", 64'(mul_reset_o), 1);
        tick;
        reset = 1'b0;
        tick;
        chk("midrst_mul_x", 64'(mul_x_o), 0);
        chk("midrst_in_ready1", 64'(in_ready_o), 1);
        send(16'd80, 16'd10, 1'b1, 0);
        push(40'd800, 4'd1, 1'b0);
        collect(0, 1'b0, 1'b1);

        // 5: narrow accumulator overflow
        sel = 1'b1;
        tick;
        send(16'hFFFF, 16'hFFFF, 1'b0, 0);
        send(16'hFFFF, 16'hFFFF, 1'b0, 0);
        send(16'hFFFF, 16'hFFFF, 1'b1, 0);
        push(40'd4294574083, 4'd3, 1'b1);
        collect(0, 1'b0, 1'b0);
        sel = 1'b0;
        tick;

        // 6: varying gaps, operand stability
        for (int g = 0; g < 8; g++) begin
            send(16'd11, 16'd33, 1'b0, g);
            send(16'd36, 16'd36, 1'b1, g);
            push(40'd1659, 4'd2, 1'b0);
            collect(0, 1'b0, 1'b0);
        end
        chk("operands_stable", 64'(xy_bad), 0);
        chk("sb_drained", 64'(sbq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
